// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants: FSM state encoding, reset/step defaults
// and PC alignment helper used by the fetch stage and its next-PC selector.
package mips_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } fetch_state_e;

    localparam logic [31:0]         RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0]         PC_STEP          = 32'd4;
    localparam int                  INSTR_W          = 32;
    localparam logic [INSTR_W-1:0]  NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0]         PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    // Word-align an address by clearing its two byte-offset bits.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC selection: aligned redirect target when a redirect is
// presented, otherwise sequential increment (wraps modulo 2^32).
module if_next_pc
    import mips_pkg::*;
#(
    parameter logic [31:0] STEP = PC_STEP
) (
    input  logic [31:0] i_pc,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pcnext
);

    logic [31:0] w_pc_inc;
    logic [31:0] w_target;

    assign w_pc_inc = i_pc + STEP;
    assign w_target = align_pc(i_redirect_pc);
    assign o_pcnext = i_redirect_valid ? w_target : w_pc_inc;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the PC, the imem req/ack handshake and the
// valid/ready hand-off to decode. Define IF_MISALIGN_TRAP_EN to trap misaligned redirects.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = mips_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] pc,
    output logic [31:0] pcnext,
    output logic        fetch_err
);

    fetch_state_e       r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_drain_addr;
    logic [INSTR_W-1:0] r_if_instr;
    logic [31:0]        r_if_pc;
    logic               r_if_valid;
    logic [31:0]        w_pcnext;

    if_next_pc #(
        .STEP             (PC_STEP)
    ) u_next_pc (
        .i_pc             (r_pc),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_pcnext         (w_pcnext)
    );

`ifdef IF_MISALIGN_TRAP_EN
    logic r_fetch_err;
    logic w_trap;

    assign w_trap    = redirect_valid && (redirect_pc[1:0] != 2'b00) && (r_state != HALT);
    assign fetch_err = r_fetch_err;
`else
    assign fetch_err = 1'b0;
`endif

    // A squashed fetch keeps presenting its original address until memory acks it.
    assign imem_req  = (r_state == FETCH) || (r_state == DRAIN);
    assign imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

    assign pc        = r_pc;
    assign pcnext    = w_pcnext;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_if_instr   <= NOP_INSTR;
            r_if_pc      <= RESET_PC;
            r_if_valid   <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            r_fetch_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= FETCH;
                    if (redirect_valid) begin
                        r_pc <= w_pcnext;
                    end
                end
                FETCH: begin
                    if (redirect_valid) begin
                        r_pc <= w_pcnext;
                        if (!imem_ack) begin
                            r_drain_addr <= r_pc;
                            r_state      <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_if_instr <= imem_rdata;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_pc       <= w_pcnext;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    // A redirect wins over a same-cycle transfer; the buffered word is dropped.
                    if (redirect_valid) begin
                        r_pc       <= w_pcnext;
                        r_if_valid <= 1'b0;
                        r_state    <= FETCH;
                    end else if (if_ready) begin
                        r_if_valid <= 1'b0;
                        r_state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        r_pc <= w_pcnext;
                    end
                    if (imem_ack) begin
                        r_state <= FETCH;
                    end
                end
                HALT: begin
                    r_if_valid <= 1'b0;
                end
                default: begin
                    r_state    <= BOOT;
                    r_if_valid <= 1'b0;
                end
            endcase
`ifdef IF_MISALIGN_TRAP_EN
            // Trap keeps the raw target in pc so a debugger can see the bad address.
            if (w_trap) begin
                r_pc        <= redirect_pc;
                r_if_valid  <= 1'b0;
                r_fetch_err <= 1'b1;
                r_state     <= HALT;
            end
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized self-checking bench for if_fetch_stage against a transaction-level
// model of the fetch stream (expected PC, buffered instruction, squashed request).
`timescale 1ns/1ps
module tb_if_fetch_stage;

`ifdef IF_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b1;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] pc;
    logic [31:0] pcnext;
    logic        fetch_err;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .pc             (pc),
        .pcnext         (pcnext),
        .fetch_err      (fetch_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the fetch stream should look like.
    logic [31:0] m_pc;
    logic [31:0] m_buf_pc;
    logic [31:0] m_stale_addr;
    bit          m_boot;
    bit          m_buf_valid;
    bit          m_stale;
    bit          m_halt;
    bit          m_err;

    // Memory / stimulus knobs.
    int          mem_wait;
    int          lat_fixed;
    int          ready_pct;
    int          redir_pct;
    logic [31:0] deliv_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int next_lat();
        if (lat_fixed >= 0) return lat_fixed;
        return int'($urandom_range(3, 0));
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom & 32'h0000_0FFF;
        if (TRAP) t = t & 32'hFFFF_FFFC;
        return t;
    endfunction

    // One clock cycle: starts and ends just after a falling edge.
    task automatic do_cycle(input bit force_rd, input logic [31:0] force_tgt);
        bit          exp_req;
        bit          rd;
        bit          ack;
        logic [31:0] tgt;
        logic [31:0] seen_pc;
        logic [31:0] seen_instr;
        logic [31:0] exp_addr;

        exp_req  = !m_boot && !m_halt && !m_buf_valid;
        exp_addr = m_stale ? m_stale_addr : m_pc;
        check_val("pc", pc, m_pc);
        check_val("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check_val("imem_addr", imem_addr, exp_addr);
        check_val("if_valid", 32'(if_valid), 32'(m_buf_valid));
        if (m_buf_valid) begin
            check_val("if_pc", if_pc, m_buf_pc);
            check_val("if_instr", if_instr, m_buf_pc + 32'h1000);
        end
        check_val("fetch_err", 32'(fetch_err), 32'(m_err));

        ack        = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (imem_req) begin
            if (mem_wait == 0) begin
                ack        = 1'b1;
                imem_rdata = imem_addr + 32'h1000;
                mem_wait   = next_lat();
            end else begin
                mem_wait--;
            end
        end
        imem_ack       = ack;
        if_ready       = ($urandom_range(99, 0) < ready_pct);
        rd             = force_rd || ((redir_pct > 0) && ($urandom_range(99, 0) < redir_pct));
        tgt            = force_rd ? force_tgt : rand_tgt();
        redirect_valid = rd;
        redirect_pc    = tgt;
        #1;
        check_val("pcnext", pcnext, rd ? (tgt & 32'hFFFF_FFFC) : (m_pc + 32'd4));
        seen_pc    = if_pc;
        seen_instr = if_instr;

        @(posedge clk);
        if (m_halt) begin
            // halted: nothing moves
        end else if (TRAP && rd && (tgt[1:0] != 2'b00)) begin
            m_halt      = 1'b1;
            m_err       = 1'b1;
            m_pc        = tgt;
            m_buf_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (rd) m_pc = tgt & 32'hFFFF_FFFC;
        end else if (rd) begin
            if (exp_req) begin
                if (ack) begin
                    m_stale = 1'b0;
                end else if (!m_stale) begin
                    m_stale      = 1'b1;
                    m_stale_addr = m_pc;
                end
            end
            m_pc        = tgt & 32'hFFFF_FFFC;
            m_buf_valid = 1'b0;
        end else if (m_buf_valid) begin
            if (if_ready) begin
                m_buf_valid = 1'b0;
                deliv_q.push_back(seen_pc);
                $display("xfer pc=%h instr=%h t=%0t", seen_pc, seen_instr, $time);
            end
        end else if (ack) begin
            if (m_stale) begin
                m_stale = 1'b0;
            end else begin
                m_buf_valid = 1'b1;
                m_buf_pc    = m_pc;
                m_pc        = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        m_pc = 32'h0; m_buf_pc = 32'h0; m_stale_addr = 32'h0;
        m_boot = 1'b1; m_buf_valid = 1'b0; m_stale = 1'b0; m_halt = 1'b0; m_err = 1'b0;
        mem_wait = 0; lat_fixed = 0; ready_pct = 100; redir_pct = 0;

        // Reset hold
        #12;
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_imem_req", 32'(imem_req), 32'h0);
        check_val("rst_if_valid", 32'(if_valid), 32'h0);
        check_val("rst_if_pc", if_pc, 32'h0);
        check_val("rst_if_instr", if_instr, 32'h0);
        check_val("rst_fetch_err", 32'(fetch_err), 32'h0);
        #10;
        check_val("rst_hold_req", 32'(imem_req), 32'h0);
        check_val("rst_hold_pc", pc, 32'h0);
        #3;
        reset = 1'b1;
        #1;

        // Zero-wait memory, decode always ready
        for (int i = 0; i < 22; i++) do_cycle(1'b0, 32'h0);
        check_val("stream_len", 32'(deliv_q.size() >= 9), 32'h1);
        for (int i = 0; i < 9 && i < deliv_q.size(); i++)
            check_val("stream_pc", deliv_q[i], 32'(i * 4));

        // Backpressure in HOLD
        ready_pct = 0;
        for (int i = 0; i < 10 && !if_valid; i++) do_cycle(1'b0, 32'h0);
        check_val("bp_reach_hold", 32'(if_valid), 32'h1);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 32'h0);
        ready_pct = 100;
        deliv_q.delete();
        do_cycle(1'b0, 32'h0);
        check_val("bp_first_xfer", 32'(deliv_q.size()), 32'h1);

        // Redirect while a 3-cycle ack is outstanding
        lat_fixed = 3;
        for (int i = 0; i < 20 && !(imem_req && mem_wait == 3); i++) do_cycle(1'b0, 32'h0);
        check_val("drain_setup", 32'(imem_req && mem_wait == 3), 32'h1);
        deliv_q.delete();
        do_cycle(1'b1, 32'h40);
        for (int i = 0; i < 30 && deliv_q.size() == 0; i++) do_cycle(1'b0, 32'h0);
        check_val("drain_first_pc", (deliv_q.size() > 0) ? deliv_q[0] : 32'hFFFF_FFFF, 32'h40);

        // Wrap around the top of the address space
        lat_fixed = 0;
        deliv_q.delete();
        do_cycle(1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 20 && deliv_q.size() < 2; i++) do_cycle(1'b0, 32'h0);
        check_val("wrap_pc0", (deliv_q.size() > 0) ? deliv_q[0] : 32'h1, 32'hFFFF_FFFC);
        check_val("wrap_pc1", (deliv_q.size() > 1) ? deliv_q[1] : 32'h1, 32'h0);

        // Random traffic
        lat_fixed = -1;
        ready_pct = 70;
        redir_pct = 5;
        for (int i = 0; i < 300; i++) do_cycle(1'b0, 32'h0);

        // Misaligned redirect
        redir_pct = 0;
        ready_pct = 100;
        lat_fixed = 0;
        deliv_q.delete();
        do_cycle(1'b1, 32'h22);
        if (TRAP) begin
            for (int i = 0; i < 5; i++) do_cycle(1'b0, 32'h0);
            check_val("trap_err", 32'(fetch_err), 32'h1);
            check_val("trap_no_req", 32'(imem_req), 32'h0);
            check_val("trap_pc", pc, 32'h22);
        end else begin
            for (int i = 0; i < 20 && deliv_q.size() == 0; i++) do_cycle(1'b0, 32'h0);
            check_val("misalign_pc", (deliv_q.size() > 0) ? deliv_q[0] : 32'hFFFF_FFFF, 32'h20);
            check_val("misalign_err", 32'(fetch_err), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
